truth_table_sweeper: RTL and testbench

- Sequential exhaustive stimulus generator and response checker for a 4-input combinational function under test (DUT), such as the NOR-level K-map minimized function f = A'D + C'D.
- Drives all 2^N_IN input combinations in ascending order and waits a settle interval on each vector.
- Samples the DUT output and compares it against a minterm/don't-care specification held in parameters.
- Sits between a start/status controller (switches/LEDs on the lab board, or a bench) and the DUT inputs a, b, c, d and output f.

---
 rtl/truth_table_sweeper_if.sv | 26 ++
 rtl/truth_table_sweeper.sv | 102 ++++++++++
 tb/tb_truth_table_sweeper.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bus between the sweeper, its start/status controller and the function under test.
// The sweeper sits on the slave modport; the controller/bench drives from master.
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    logic            start;
    logic [N_IN-1:0] stim;
    logic            dut_f;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            fail_seen;
    logic [N_IN-1:0] first_fail;
    logic [1:0]      state_dbg;

    modport master (
        output start, dut_f,
        input  stim, busy, done, pass, err_count, fail_seen, first_fail, state_dbg
    );

    modport slave (
        input  start, dut_f,
        output stim, busy, done, pass, err_count, fail_seen, first_fail, state_dbg
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus generator / response checker for a small combinational function.
// Walks every input index, holds each for SETTLE+1 cycles, and scores dut_f against MINTERMS.
module truth_table_sweeper #(
    parameter int                    N_IN       = 4,
    parameter logic [(1<<N_IN)-1:0]  MINTERMS   = 16'h02AA,
    parameter logic [(1<<N_IN)-1:0]  DONT_CARES = 16'h3040,
    parameter int                    SETTLE     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int              CW          = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE);
    localparam logic [N_IN-1:0] LAST_IDX    = N_IN'((1 << N_IN) - 1);

    // Handshake: start is a level request honoured only in IDLE; busy is high for the
    // whole sweep, done pulses for one cycle, and status outputs update only on that pulse.
    logic [1:0]      state;
    logic [CW-1:0]   settle_cnt;
    logic [N_IN-1:0] stim;
    logic [N_IN:0]   err_work;
    logic [N_IN-1:0] first_work;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            fail_seen;
    logic [N_IN-1:0] first_fail;

    logic            mismatch;
    logic [N_IN:0]   err_next;
    logic [N_IN-1:0] first_next;

    // Only consumed at the last edge of a vector, when dut_f has had SETTLE+1 cycles.
    always_comb begin
        mismatch   = !DONT_CARES[stim] && (bus.dut_f != MINTERMS[stim]);
        err_next   = err_work + (N_IN+1)'(mismatch);
        first_next = (mismatch && (err_work == '0)) ? stim : first_work;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            stim       <= '0;
            err_work   <= '0;
            first_work <= '0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    stim       <= '0;
                    settle_cnt <= '0;
                    err_work   <= '0;
                    first_work <= '0;
                    if (bus.start) state <= S_DRIVE;
                end
                S_DRIVE: begin
                    if (settle_cnt != SETTLE_LAST) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end else begin
                        settle_cnt <= '0;
                        err_work   <= err_next;
                        first_work <= first_next;
                        if (stim != LAST_IDX) begin
                            stim <= stim + 1'b1;
                        end else begin
                            // Publish from the next-values so the final vector is included.
                            state      <= S_DONE;
                            stim       <= '0;
                            err_count  <= err_next;
                            fail_seen  <= (err_next != '0);
                            first_fail <= first_next;
                            pass       <= (err_next == '0);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stim       = stim;
    assign bus.busy       = (state == S_DRIVE);
    assign bus.done       = (state == S_DONE);
    assign bus.pass       = pass;
    assign bus.err_count  = err_count;
    assign bus.fail_seen  = fail_seen;
    assign bus.first_fail = first_fail;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: fault-injected DUT models with hand-computed results,
// timing of done, start filtering, async abort, and a SETTLE=0 instance.
module tb_truth_table_sweeper;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   mode;
    int   mode0;
    logic [31:0] exp_q[$];

    truth_table_sweeper_if #(.N_IN(4)) bus ();
    truth_table_sweeper_if #(.N_IN(4)) bus0 ();

    truth_table_sweeper u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    truth_table_sweeper #(.SETTLE(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function under test: f = a'd + c'd, with fault modes layered on top.
    function automatic logic model_f(input logic [3:0] s, input int m);
        logic f;
        f = (~s[3] & s[0]) | (~s[1] & s[0]);
        case (m)
            1: f = 1'b0;
            2: f = 1'b1;
            3: if (s == 4'd6 || s == 4'd12 || s == 4'd13) f = 1'b1;
            4: if (s == 4'd6 || s == 4'd12 || s == 4'd13 || s == 4'd11) f = 1'b1;
            default: ;
        endcase
        return f;
    endfunction

    always_comb bus.dut_f  = model_f(bus.stim, mode);
    always_comb bus0.dut_f = model_f(bus0.stim, mode0);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic p, input int ec,
                                input logic fs, input int ff);
        check_eq({tag, "_pass"},       32'(bus.pass),       32'(p));
        check_eq({tag, "_err_count"},  32'(bus.err_count),  ec);
        check_eq({tag, "_fail_seen"},  32'(bus.fail_seen),  32'(fs));
        check_eq({tag, "_first_fail"}, 32'(bus.first_fail), ff);
    endtask

    // Driver: pulse start on the default instance and follow the sweep to done.
    // repulse_at re-raises start at that cycle; abort_at asserts reset at that cycle.
    task automatic run_sweep(input string tag, input bit trace, input int repulse_at,
                             input int abort_at, input logic prev_pass);
        int  e;
        bit  got;
        bit  aborted;
        e = 0; got = 1'b0; aborted = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq({tag, "_busy_t0"}, 32'(bus.busy), 1);
        if (trace)
            for (int k = 0; k < 16; k++) repeat (3) exp_q.push_back(k);
        while (!got && !aborted && e < 200) begin
            if (trace && exp_q.size() > 0)
                check_eq({tag, "_stim_seq"}, 32'(bus.stim), exp_q.pop_front());
            if (e == 30)
                check_eq({tag, "_pass_held"}, 32'(bus.pass), 32'(prev_pass));
            @(posedge clk);
            e++;
            #1;
            bus.start = (e == repulse_at);
            if (e == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq({tag, "_rst_stim"},  32'(bus.stim),       0);
                check_eq({tag, "_rst_busy"},  32'(bus.busy),       0);
                check_eq({tag, "_rst_done"},  32'(bus.done),       0);
                check_status({tag, "_rst"}, 1'b0, 0, 1'b0, 0);
                aborted = 1'b1;
            end else if (bus.done) begin
                got = 1'b1;
            end
        end
        bus.start = 1'b0;
        if (!aborted) begin
            check_eq({tag, "_done_seen"},  32'(got), 1);
            check_eq({tag, "_done_edges"}, e, 48);
            check_eq({tag, "_stim_done"},  32'(bus.stim), 0);
            @(posedge clk);
            #1;
            check_eq({tag, "_done_pulse"}, 32'(bus.done), 0);
            check_eq({tag, "_busy_after"}, 32'(bus.busy), 0);
        end
    endtask

    initial begin
        int  e;
        bit  got;
        bit  saw;
        checks = 0; failures = 0; mode = 0; mode0 = 0;
        rst_n = 1'b0;
        bus.start  = 1'b0;
        bus0.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", 32'(bus.state_dbg), 0);
        check_eq("reset_stim",  32'(bus.stim), 0);
        check_eq("reset_busy",  32'(bus.busy), 0);
        check_eq("reset_done",  32'(bus.done), 0);
        check_status("reset", 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        mode = 0;
        run_sweep("correct", 1'b1, -1, -1, 1'b0);
        check_status("correct", 1'b1, 0, 1'b0, 0);

        mode = 1;
        run_sweep("stuck0", 1'b0, -1, -1, 1'b1);
        check_status("stuck0", 1'b0, 5, 1'b1, 1);

        mode = 2;
        run_sweep("stuck1", 1'b0, -1, -1, 1'b0);
        check_status("stuck1", 1'b0, 8, 1'b1, 0);

        mode = 3;
        run_sweep("dontcare", 1'b0, -1, -1, 1'b0);
        check_status("dontcare", 1'b1, 0, 1'b0, 0);

        mode = 4;
        run_sweep("idx11", 1'b0, -1, -1, 1'b1);
        check_status("idx11", 1'b0, 1, 1'b1, 11);

        mode = 0;
        run_sweep("repulse", 1'b0, 10, -1, 1'b0);
        check_status("repulse", 1'b1, 0, 1'b0, 0);

        // Held start: done-to-done spacing is a full sweep plus DONE and IDLE.
        @(negedge clk);
        bus.start = 1'b1;
        got = 1'b0; e = 0;
        while (!got && e < 200) begin @(posedge clk); e++; #1; got = bus.done; end
        check_eq("held_first_done", 32'(got), 1);
        got = 1'b0; e = 0;
        while (!got && e < 200) begin @(posedge clk); e++; #1; got = bus.done; end
        bus.start = 1'b0;
        check_eq("held_second_done", 32'(got), 1);
        check_eq("held_period", e, 50);
        @(posedge clk);
        #1;

        run_sweep("abort", 1'b0, -1, 20, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) saw = 1'b1;
        end
        check_eq("abort_no_done", 32'(saw), 0);

        run_sweep("post_abort", 1'b0, -1, -1, 1'b0);
        check_status("post_abort", 1'b1, 0, 1'b0, 0);

        // SETTLE=0 instance: one edge per vector.
        mode0 = 0;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        check_eq("s0_busy_t0", 32'(bus0.busy), 1);
        got = 1'b0; e = 0;
        while (!got && e < 100) begin
            check_eq("s0_stim_seq", 32'(bus0.stim), e);
            @(posedge clk); e++; #1; got = bus0.done;
        end
        check_eq("s0_done_seen",  32'(got), 1);
        check_eq("s0_done_edges", e, 16);
        check_eq("s0_pass",       32'(bus0.pass), 1);
        check_eq("s0_err_count",  32'(bus0.err_count), 0);

        mode0 = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        got = 1'b0; e = 0;
        while (!got && e < 100) begin @(posedge clk); e++; #1; got = bus0.done; end
        check_eq("s0_stuck0_done",  32'(got), 1);
        check_eq("s0_stuck0_err",   32'(bus0.err_count), 5);
        check_eq("s0_stuck0_first", 32'(bus0.first_fail), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
